// File: rtl/cpu_board_io.sv
// rtl/cpu_board_io.sv - step-button debouncer, CPU clock source and 4-digit seven-segment scanner
// Optional feature macro: AUTO_RUN_EN (adds auto_run, a free-running cpu_clk mode)
module cpu_board_io #(
   parameter int DEB_CYCLES = 500000,
   parameter int SCAN_DIV   = 100000
`ifdef AUTO_RUN_EN
   ,
   parameter int AUTO_DIV   = 25000000
`endif
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        step_btn,
`ifdef AUTO_RUN_EN
   input  logic        auto_run,
`endif
   input  logic [1:0]  sel,
   input  logic [31:0] currentIAddr,
   input  logic [31:0] nextIAddr,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   input  logic [31:0] ALU_result,
   input  logic [31:0] DataBus,
   output logic        cpu_clk,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] deb_cnt;
   logic [DW-1:0] deb_cnt_next;
   logic          deb_level;
   logic          deb_level_next;
   logic [SW-1:0] scan_cnt;
   logic          scan_wrap;
   logic [1:0]    digit;
   logic [15:0]   frame;
   logic [15:0]   page_value;

   // Only the low byte of each wide debug bus is ever displayed.
   logic unused_bits;
   assign unused_bits = ^{currentIAddr[31:8], nextIAddr[31:8], ReadData1[31:8],
                          ReadData2[31:8], ALU_result[31:8], DataBus[31:8]};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Two-flop synchroniser for the asynchronous push-button.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= step_btn;
         sync2 <= sync1;
      end
   end

   // Debounce: a level change needs DEB_CYCLES consecutive differing samples.
   always_comb begin
      deb_cnt_next   = '0;
      deb_level_next = deb_level;
      if (sync2 != deb_level) begin
         if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_level_next = ~deb_level;
         end else begin
            deb_cnt_next = deb_cnt + 1'b1;
         end
      end
   end

   // Debounce counter and debounced level registers.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         deb_cnt   <= '0;
         deb_level <= 1'b0;
      end else begin
         deb_cnt   <= deb_cnt_next;
         deb_level <= deb_level_next;
      end
   end

`ifdef AUTO_RUN_EN
   localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   logic [AW-1:0] auto_cnt;
   logic          auto_tick;
   logic          cpu_clk_r;

   assign auto_tick = (auto_cnt == AW'(AUTO_DIV - 1));

   // Auto-run divider; held at zero whenever auto_run is low.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         auto_cnt <= '0;
      end else if (!auto_run || auto_tick) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end

   // cpu_clk free-runs in auto mode, otherwise tracks the debounced level.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         cpu_clk_r <= 1'b0;
      end else if (auto_run) begin
         if (auto_tick) begin
            cpu_clk_r <= ~cpu_clk_r;
         end
      end else begin
         cpu_clk_r <= deb_level_next;
      end
   end

   assign cpu_clk = cpu_clk_r;
`else
   assign cpu_clk = deb_level;
`endif

   // Page select: left byte in [15:8], right byte in [7:0].
   always_comb begin
      page_value = {currentIAddr[7:0], nextIAddr[7:0]};
      case (sel)
         2'd1:    page_value = {3'b000, rs, ReadData1[7:0]};
         2'd2:    page_value = {3'b000, rt, ReadData2[7:0]};
         2'd3:    page_value = {ALU_result[7:0], DataBus[7:0]};
         default: page_value = {currentIAddr[7:0], nextIAddr[7:0]};
      endcase
   end

   assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

   // Digit scan; the frame is latched only at the 3->0 rollover so a frame never tears.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         scan_cnt <= '0;
         digit    <= 2'd0;
         frame    <= 16'h0000;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         digit    <= digit + 2'd1;
         if (digit == 2'd3) begin
            frame <= page_value;
         end
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Registered anode/segment drive; dp lit on digit 2 to split the two bytes.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         an  <= 4'hF;
         seg <= 8'hFF;
      end else begin
         an  <= ~(4'b0001 << digit);
         seg <= {(digit != 2'd2), hex7(frame[{digit, 2'b00} +: 4])};
      end
   end

endmodule

// File: tb/tb_cpu_board_io.sv
// tb/tb_cpu_board_io.sv - scoreboard bench for cpu_board_io with a cycle-count reference model
module tb_cpu_board_io;

   localparam int DEB  = 4;
   localparam int SCAN = 2;
   localparam int AUTO = 3;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        step_btn = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [31:0] cur = '0, nxt = '0, rd1 = '0, rd2 = '0, alu = '0, dbus = '0;
   logic [4:0]  rs = '0, rt = '0;
`ifdef AUTO_RUN_EN
   logic        auto_run = 1'b0;
`endif
   wire         cpu_clk;
   wire  [3:0]  an;
   wire  [7:0]  seg;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   cpu_board_io #(
      .DEB_CYCLES(DEB),
      .SCAN_DIV(SCAN)
`ifdef AUTO_RUN_EN
      ,
      .AUTO_DIV(AUTO)
`endif
   ) dut (
      .clk(clk),
      .Reset(Reset),
      .step_btn(step_btn),
`ifdef AUTO_RUN_EN
      .auto_run(auto_run),
`endif
      .sel(sel),
      .currentIAddr(cur),
      .nextIAddr(nxt),
      .rs(rs),
      .rt(rt),
      .ReadData1(rd1),
      .ReadData2(rd2),
      .ALU_result(alu),
      .DataBus(dbus),
      .cpu_clk(cpu_clk),
      .an(an),
      .seg(seg)
   );

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   function automatic logic [15:0] page();
      case (sel)
         2'd0:    return {cur[7:0], nxt[7:0]};
         2'd1:    return {3'b000, rs, rd1[7:0]};
         2'd2:    return {3'b000, rt, rd2[7:0]};
         default: return {alu[7:0], dbus[7:0]};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected-response queues filled by the model, drained by the monitor.
   logic [11:0] dq[$];
   logic        cq[$];

   // Reference model: edge count since reset release decides which digit/frame is shown;
   // the button level flips after DEB consecutive 2-cycle-delayed raw samples disagree with it.
   int          e, d, streak, acnt;
   logic [15:0] mframe;
   logic        hist[$];
   logic        lvl, exp_clk, old;
   logic [11:0] exp12;

   always @(posedge clk) begin
      if (Reset) begin
         e = 0; mframe = '0; lvl = 1'b0; streak = 0; exp_clk = 1'b0; acnt = 0;
         hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
         dq.delete(); cq.delete();
      end else begin
         e++;
         hist.push_back(step_btn);
         old = hist.pop_front();
         if (old != lvl) begin
            streak++;
            if (streak == DEB) begin
               lvl = ~lvl;
               streak = 0;
            end
         end else begin
            streak = 0;
         end
`ifdef AUTO_RUN_EN
         if (auto_run) begin
            acnt++;
            if (acnt == AUTO) begin
               exp_clk = ~exp_clk;
               acnt = 0;
            end
         end else begin
            acnt = 0;
            exp_clk = lvl;
         end
`else
         exp_clk = lvl;
`endif
         cq.push_back(exp_clk);
         if ((e - 1) % SCAN == 0) begin
            d = ((e - 1) / SCAN) % 4;
            exp12 = {4'(~(4'b0001 << d)), (d != 2), enc(mframe[4*d +: 4])};
            dq.push_back(exp12);
         end
         if (e % (4 * SCAN) == 0) mframe = page();
      end
   end

   // Monitor: cpu_clk every cycle, a display entry on each anode change plus its dwell time.
   logic [3:0] prev_an = 4'hF;
   int         run = 0;

   always @(negedge clk) begin
      if (Reset) begin
         prev_an = 4'hF;
         run = 0;
      end else begin
         check("cpu_clk_queue_nonempty", 32'(cq.size() != 0), 32'd1);
         if (cq.size() != 0) check("cpu_clk", 32'(cpu_clk), 32'(cq.pop_front()));
         if (an != prev_an) begin
            if (prev_an != 4'hF) check("digit_dwell", 32'(run), 32'(SCAN));
            check("digit_queue_nonempty", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) check("digit_an_seg", 32'({an, seg}), 32'(dq.pop_front()));
            prev_an = an;
            run = 1;
         end else begin
            run++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cpu_clk"}, 32'(cpu_clk), 32'd0);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'hFF);
      check({tag, "_frame"}, 32'(dut.frame), 32'h0);
   endtask

   initial begin
      tick(3);
      #1 check_reset_state("rst_initial");
      #1 Reset = 1'b0;

      // Page 00 showing 14.18 while the button bounces, then a clean press and release.
      sel = 2'd0; cur = 32'h0000_0014; nxt = 32'h0000_0018;
      for (int i = 0; i < 3; i++) begin
         tick(1); step_btn = 1'b1;
         tick(3); step_btn = 1'b0;
         tick(1);
      end
      tick(1); step_btn = 1'b1;
      tick(10); step_btn = 1'b0;
      tick(12);

      // Page 01: 1F.Ab
      sel = 2'd1; rs = 5'd31; rd1 = 32'h0000_00AB;
      tick(24);

      // Page 00, then switch to page 11 (C3.5E) part way through a frame.
      sel = 2'd0;
      tick(11);
      sel = 2'd3; alu = 32'h0000_00C3; dbus = 32'h0000_005E;
      tick(24);

      // Randomized button activity and page/data changes at arbitrary points.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: step_btn = ~step_btn;
            1: sel = 2'($urandom_range(0, 3));
            2: begin
               cur = $urandom(); nxt = $urandom(); rd1 = $urandom(); rd2 = $urandom();
               alu = $urandom(); dbus = $urandom(); rs = 5'($urandom()); rt = 5'($urandom());
            end
            default: begin
               step_btn = 1'b1;
               tick($urandom_range(1, 6));
               step_btn = 1'b0;
            end
         endcase
         tick($urandom_range(1, 12));
      end

      // Asynchronous reset pulse in the middle of a held press.
      step_btn = 1'b1;
      tick(10);
      #2 Reset = 1'b1;
      #1 check_reset_state("rst_async");
      tick(3);
      #2 Reset = 1'b0;
      tick(20);
      step_btn = 1'b0;
      tick(12);

`ifdef AUTO_RUN_EN
      auto_run = 1'b1;
      tick(20);
      auto_run = 1'b0;
      tick(6);
`endif

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
